// File: rtl/burst_line_ctrl.sv
// Line-wide request front end for a burst RAM: one line = BurstDataCount words, one command per line.
// Command issues the cycle after accept; reads complete one cycle after the last beat; req_ready low while busy or not idle.
module burst_line_ctrl #(
  parameter int RamAddressBitWidth = 21,
  parameter int DataBitWidth       = 64,
  parameter int BurstDataCount     = 4,
  localparam int CntBitWidth       = $clog2(BurstDataCount),
  localparam int LineBitWidth      = DataBitWidth * BurstDataCount,
  localparam int LineAddrBitWidth  = RamAddressBitWidth - CntBitWidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [LineAddrBitWidth-1:0]   req_addr,
  input  logic [LineBitWidth-1:0]       req_wr_data,
  output logic                          resp_valid,
  output logic [LineBitWidth-1:0]       resp_rd_data,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RamAddressBitWidth-1:0] br_addr,
  output logic [DataBitWidth-1:0]       br_wr_data,
  output logic [DataBitWidth/8-1:0]     br_data_mask,
  input  logic [DataBitWidth-1:0]       br_rd_data,
  input  logic                          br_rd_data_valid,
  input  logic                          br_init_calib,
  input  logic                          br_busy
);

  typedef enum logic [2:0] {CALIB, IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

  state_t                  state;
  logic [CntBitWidth-1:0]  word_cnt;
  logic [LineBitWidth-1:0] wr_line;
  logic [LineBitWidth-1:0] rd_line;
  logic [LineBitWidth-1:0] rd_line_next;
  logic                    accept;

  // Holding off while resp_valid is high keeps back-to-back requests a cycle apart.
  assign req_ready    = (state == IDLE) && !br_busy && br_init_calib && !resp_valid;
  assign accept       = req_valid && req_ready;
  assign br_data_mask = '0;

  always_comb begin
    rd_line_next = rd_line;
    rd_line_next[32'(word_cnt) * DataBitWidth +: DataBitWidth] = br_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CALIB;
      resp_valid   <= 1'b0;
      resp_rd_data <= '0;
      br_cmd       <= 1'b0;
      br_cmd_en    <= 1'b0;
      br_addr      <= '0;
      br_wr_data   <= '0;
      word_cnt     <= '0;
      wr_line      <= '0;
      rd_line      <= '0;
    end else begin
      resp_valid <= 1'b0;
      br_cmd_en  <= 1'b0;
      unique case (state)
        CALIB: begin
          if (br_init_calib && !br_busy) state <= IDLE;
        end
        IDLE: begin
          if (!br_init_calib) begin
            state <= CALIB;
          end else if (accept) begin
            br_cmd_en <= 1'b1;
            br_cmd    <= req_write;
            br_addr   <= {req_addr, {CntBitWidth{1'b0}}};
            word_cnt  <= '0;
            if (req_write) begin
              wr_line    <= req_wr_data;
              br_wr_data <= req_wr_data[DataBitWidth-1:0];
              word_cnt   <= CntBitWidth'(1);
              state      <= WR_BURST;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        WR_BURST: begin
          // The counter wraps to zero once the last word has gone out.
          if (word_cnt == '0) begin
            resp_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            br_wr_data <= wr_line[32'(word_cnt) * DataBitWidth +: DataBitWidth];
            word_cnt   <= word_cnt + CntBitWidth'(1);
          end
        end
        RD_WAIT, RD_BURST: begin
          if (br_rd_data_valid) begin
            rd_line  <= rd_line_next;
            word_cnt <= word_cnt + CntBitWidth'(1);
            if (word_cnt == CntBitWidth'(BurstDataCount - 1)) begin
              resp_rd_data <= rd_line_next;
              resp_valid   <= 1'b1;
              state        <= IDLE;
            end else begin
              state <= RD_BURST;
            end
          end
        end
        default: state <= CALIB;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_ctrl.sv
// Directed bench for burst_line_ctrl: per-cycle vector table plus calibration, RAM-model and reset-abort sequences.
module tb_burst_line_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [18:0]   req_addr;
  logic [255:0]  req_wr_data;
  logic          resp_valid;
  logic [255:0]  resp_rd_data;
  logic          br_cmd, br_cmd_en;
  logic [20:0]   br_addr;
  logic [63:0]   br_wr_data;
  logic [7:0]    br_data_mask;
  logic [63:0]   br_rd_data;
  logic          br_rd_data_valid, br_init_calib, br_busy;

  logic          model_en = 1'b0;
  logic          t_dv, t_cal, t_busy;
  logic [63:0]   t_dd;
  logic          m_busy = 1'b0, m_dv = 1'b0;
  logic [63:0]   m_dd = '0;

  assign br_rd_data       = model_en ? m_dd   : t_dd;
  assign br_rd_data_valid = model_en ? m_dv   : t_dv;
  assign br_busy          = model_en ? m_busy : t_busy;
  assign br_init_calib    = t_cal;

  always #5 clk = ~clk;

  burst_line_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .resp_valid(resp_valid), .resp_rd_data(resp_rd_data),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
    .br_init_calib(br_init_calib), .br_busy(br_busy)
  );

  // Burst RAM model: stores write bursts, returns reads 3 cycles after the command, stays busy a while after.
  logic [63:0] mem [logic [20:0]];
  logic [20:0] m_addr = '0;
  logic        m_wr = 1'b0;
  int          m_t = 0, m_k = 0;
  int          cmd_cnt = 0, cmd_busy_err = 0;

  always @(negedge clk) begin
    if (!model_en) begin
      m_busy = 1'b0;
      m_dv   = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (br_cmd_en) begin
        cmd_cnt++;
        if (m_busy) cmd_busy_err++;
        m_busy = 1'b1; m_addr = br_addr; m_wr = br_cmd; m_t = 0; m_k = 0;
        if (br_cmd) begin mem[br_addr] = br_wr_data; m_k = 1; end
      end else if (m_busy) begin
        m_t++;
        if (m_wr) begin
          if (m_k < 4) begin mem[m_addr + 21'(m_k)] = br_wr_data; m_k++; end
          else if (m_t > 5) m_busy = 1'b0;
        end else if (m_k < 4) begin
          if (m_t >= 3) begin m_dv = 1'b1; m_dd = mem[m_addr + 21'(m_k)]; m_k++; end
        end else if (m_t > 8) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic         rv, rw;
    logic [18:0]  ra;
    logic [255:0] rdat;
    logic         dv;
    logic [63:0]  dd;
    logic         cal, busy;
    logic         e_rdy, e_resp, e_cen, e_cmd;
    logic [20:0]  e_addr;
    logic [63:0]  e_wd;
    logic [255:0] e_rd;
  } vec_t;

  vec_t tab[$];
  int   n_chk = 0, n_err = 0;

  task automatic add(input logic rv, input logic rw, input logic [18:0] ra, input logic [255:0] rdat,
                     input logic dv, input logic [63:0] dd, input logic cal, input logic busy,
                     input logic e_rdy, input logic e_resp, input logic e_cen, input logic e_cmd,
                     input logic [20:0] e_addr, input logic [63:0] e_wd, input logic [255:0] e_rd);
    vec_t v;
    v.rv = rv; v.rw = rw; v.ra = ra; v.rdat = rdat; v.dv = dv; v.dd = dd; v.cal = cal; v.busy = busy;
    v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_cen = e_cen; v.e_cmd = e_cmd;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_rd = e_rd;
    tab.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called on a negedge; holds the request until accepted or the budget runs out, returns on a negedge.
  task automatic issue(input logic w, input logic [18:0] a, input logic [255:0] d, output logic ok);
    ok = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wr_data = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      #2;
      if (req_ready) ok = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] l1, r1, r2, r3, w2;
    logic         ok, got;

    l1 = {64'h44, 64'h33, 64'h22, 64'h11};
    r1 = {64'hD, 64'hC, 64'hB, 64'hA};
    r2 = {64'h4, 64'h3, 64'h2, 64'h1};
    r3 = {64'h8, 64'h7, 64'h6, 64'h5};
    w2 = {64'hCAFE_0003, 64'hBEEF_0002, 64'h1234_0001, 64'h5A5A_0000};

    // rv rw ra rdat | dv dd cal busy | rdy resp cen cmd addr wd rd
    add(1, 1, 3, l1, 0, 0, 1, 0,  1, 0, 1, 1, 21'hC, 64'h11, 0);
    add(0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1, 21'hC, 64'h22, 0);
    add(0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1, 21'hC, 64'h33, 0);
    add(0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1, 21'hC, 64'h44, 0);
    add(0, 0, 0, 0,  0, 0, 1, 0,  0, 1, 0, 1, 21'hC, 64'h44, 0);
    add(0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1, 21'hC, 64'h44, 0);
    add(1, 0, 5, 0,  0, 0, 1, 0,  1, 0, 1, 0, 21'h14, 64'h44, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 21'h14, 64'h44, 0);
    add(0, 0, 0, 0,  1, 64'hA, 1, 0,  0, 0, 0, 0, 21'h14, 64'h44, 0);
    add(0, 0, 0, 0,  1, 64'hB, 1, 0,  0, 0, 0, 0, 21'h14, 64'h44, 0);
    add(0, 0, 0, 0,  1, 64'hC, 1, 0,  0, 0, 0, 0, 21'h14, 64'h44, 0);
    add(0, 0, 0, 0,  1, 64'hD, 1, 0,  0, 1, 0, 0, 21'h14, 64'h44, r1);
    add(0, 0, 0, 0,  0, 0, 1, 0,      0, 0, 0, 0, 21'h14, 64'h44, r1);
    add(0, 0, 0, 0,  1, 64'hEE, 1, 0, 1, 0, 0, 0, 21'h14, 64'h44, r1);
    add(0, 0, 0, 0,  1, 64'hFF, 1, 0, 1, 0, 0, 0, 21'h14, 64'h44, r1);
    add(1, 0, 7, 0,  0, 0, 1, 0,      1, 0, 1, 0, 21'h1C, 64'h44, r1);
    add(0, 0, 0, 0,  0, 0, 1, 0,      0, 0, 0, 0, 21'h1C, 64'h44, r1);
    add(0, 0, 0, 0,  1, 64'h1, 1, 0,  0, 0, 0, 0, 21'h1C, 64'h44, r1);
    add(0, 0, 0, 0,  1, 64'h2, 1, 0,  0, 0, 0, 0, 21'h1C, 64'h44, r1);
    add(0, 0, 0, 0,  1, 64'h3, 1, 0,  0, 0, 0, 0, 21'h1C, 64'h44, r1);
    add(0, 0, 0, 0,  1, 64'h4, 1, 0,  0, 1, 0, 0, 21'h1C, 64'h44, r2);
    add(0, 0, 0, 0,  0, 0, 1, 0,      0, 0, 0, 0, 21'h1C, 64'h44, r2);
    add(1, 1, 9, l1, 0, 0, 1, 1,      0, 0, 0, 0, 21'h1C, 64'h44, r2);
    add(0, 0, 0, 0,  0, 0, 0, 0,      0, 0, 0, 0, 21'h1C, 64'h44, r2);
    add(0, 0, 0, 0,  0, 0, 1, 0,      0, 0, 0, 0, 21'h1C, 64'h44, r2);
    add(0, 0, 0, 0,  0, 0, 1, 0,      1, 0, 0, 0, 21'h1C, 64'h44, r2);

    // Reset values and calibration hold.
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wr_data = '0;
    t_dv = 1'b0; t_dd = '0; t_cal = 1'b0; t_busy = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_cmd_en", br_cmd_en, 0);
    chk("rst_addr", br_addr, 0);
    chk("rst_wr_data", br_wr_data, 0);
    chk("rst_rd_data", resp_rd_data, 0);
    chk("data_mask", br_data_mask, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; chk($sformatf("calib_hold%0d_ready", i), req_ready, 0);
      @(negedge clk);
    end
    t_cal = 1'b1;
    #1; chk("calib_edge_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("calib_done_ready", req_ready, 1);

    foreach (tab[i]) begin
      @(negedge clk);
      req_valid = tab[i].rv; req_write = tab[i].rw; req_addr = tab[i].ra; req_wr_data = tab[i].rdat;
      t_dv = tab[i].dv; t_dd = tab[i].dd; t_cal = tab[i].cal; t_busy = tab[i].busy;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, tab[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_resp", i), resp_valid, tab[i].e_resp);
      chk($sformatf("v%0d_cmd_en", i), br_cmd_en, tab[i].e_cen);
      chk($sformatf("v%0d_cmd", i), br_cmd, tab[i].e_cmd);
      chk($sformatf("v%0d_addr", i), br_addr, tab[i].e_addr);
      chk($sformatf("v%0d_wr_data", i), br_wr_data, tab[i].e_wd);
      chk($sformatf("v%0d_rd_data", i), resp_rd_data, tab[i].e_rd);
    end

    // Write then immediately read the same line through the RAM model.
    @(negedge clk);
    req_valid = 1'b0; t_dv = 1'b0; t_busy = 1'b0; t_cal = 1'b1; model_en = 1'b1;
    issue(1'b1, 19'h3, w2, ok);
    chk("mdl_wr_accept", ok, 1);
    issue(1'b0, 19'h3, '0, ok);
    chk("mdl_rd_accept", ok, 1);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (resp_valid) got = 1'b1;
    end
    chk("mdl_rd_resp", got, 1);
    chk("mdl_rd_data", resp_rd_data, w2);
    chk("mdl_cmd_while_busy", cmd_busy_err, 0);
    chk("mdl_cmd_count", cmd_cnt, 2);

    // Reset on the second read beat aborts the burst.
    @(negedge clk); model_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h2;
    #1; chk("abort_req_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); t_dv = 1'b1; t_dd = 64'h100;
    @(negedge clk); t_dd = 64'h200; rst = 1'b1;
    #1;
    chk("abort_ready", req_ready, 0);
    chk("abort_resp", resp_valid, 0);
    chk("abort_cmd_en", br_cmd_en, 0);
    chk("abort_cmd", br_cmd, 0);
    chk("abort_addr", br_addr, 0);
    chk("abort_wr_data", br_wr_data, 0);
    chk("abort_rd_data", resp_rd_data, 0);
    @(negedge clk); t_dd = 64'h300; #1; chk("abort_b3_resp", resp_valid, 0);
    @(negedge clk); t_dd = 64'h400; #1; chk("abort_b4_resp", resp_valid, 0);
    @(negedge clk); t_dv = 1'b0; rst = 1'b0;
    #1; chk("recal_ready_low", req_ready, 0);
    @(negedge clk); #1;
    chk("recal_resp", resp_valid, 0);
    chk("recal_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h6;
    @(posedge clk); #1;
    chk("rr_cmd_en", br_cmd_en, 1);
    chk("rr_addr", br_addr, 21'h18);
    @(negedge clk); req_valid = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk); t_dv = 1'b1; t_dd = 64'(k);
    end
    @(posedge clk); #1;
    chk("rr_resp", resp_valid, 1);
    chk("rr_rd_data", resp_rd_data, r3);
    @(negedge clk); t_dv = 1'b0;
    @(posedge clk); #1;
    chk("rr_resp_pulse", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
